// File: rtl/ky32_skid_stage.sv
// ky32_skid_stage
//   Valid/ready pipeline stage with a one-entry skid buffer. Decouples the
//   upstream stage from downstream backpressure while sustaining one word per
//   cycle, and presents a registered output.
//
//   Ports
//     clk           clock, rising edge
//     rst           asynchronous reset, active-low
//     i_flush       synchronous discard of all held words
//     i_in_valid    upstream word present
//     o_in_ready    stage can accept a word this cycle (decoded from state only)
//     i_in_data     upstream payload
//     o_out_valid   output word present
//     i_out_ready   downstream accepts the word this cycle
//     o_out_data    output payload (main slot)
//     o_count       words held: 0, 1 or 2
//
//   state   | meaning
//   --------+--------------------------------------------
//   S_EMPTY | nothing held, out_valid=0
//   S_ONE   | main slot valid, skid slot free
//   S_FULL  | main and skid valid, upstream stalled
module ky32_skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_accept;
  logic             w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Ready/valid are pure state decodes so no combinational path exists from
  // i_out_ready to o_in_ready.
  always_comb begin
    o_in_ready  = 1'b1;
    o_out_valid = 1'b0;
    o_count     = 2'd0;
    case (r_state)
      S_EMPTY: begin
        o_in_ready  = 1'b1;
        o_out_valid = 1'b0;
        o_count     = 2'd0;
      end
      S_ONE: begin
        o_in_ready  = 1'b1;
        o_out_valid = 1'b1;
        o_count     = 2'd1;
      end
      S_FULL: begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b1;
        o_count     = 2'd2;
      end
      default: begin
        o_in_ready  = 1'b1;
        o_out_valid = 1'b0;
        o_count     = 2'd0;
      end
    endcase
  end

  assign o_out_data = r_main;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_pop      = o_out_valid & i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_main_nxt  = i_in_data;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_main_nxt = i_in_data;
        end else if (w_accept) begin
          w_skid_nxt  = i_in_data;
          w_state_nxt = S_FULL;
        end else if (w_pop) begin
          // main keeps its stale value; it is hidden behind out_valid=0
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_main_nxt  = r_skid;
          w_state_nxt = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase

    // Flush discards everything, including a word accepted this cycle. A pop
    // in the same cycle has already been presented downstream.
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
    end
  end

endmodule

// File: tb/tb_ky32_skid_stage.sv
module tb_ky32_skid_stage;

  logic        clk;
  logic        rst;
  logic        i_flush;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_in_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic [1:0]  o_count;

  int total;
  int bad;

  ky32_skid_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (i_flush),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_count    (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then land on the falling edge for checks/drives
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    i_flush = 1'b0;
    i_in_valid = 1'b1;
    i_in_data = 32'hDEAD_BEEF;
    i_out_ready = 1'b0;

    // 1. reset with a word pending at the input
    step();
    step();
    chk("rst_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_count", {30'd0, o_count}, 32'd0);
    chk("rst_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_data", o_out_data, 32'd0);
    rst = 1'b1;
    step();
    i_in_valid = 1'b0;
    chk("t1_data", o_out_data, 32'hDEAD_BEEF);
    chk("t1_valid", {31'd0, o_out_valid}, 32'd1);
    chk("t1_count", {30'd0, o_count}, 32'd1);
    i_out_ready = 1'b1;
    step();
    chk("t1_drain", {31'd0, o_out_valid}, 32'd0);

    // 2. streaming at full throughput
    for (int k = 1; k <= 8; k++) begin
      i_in_valid = 1'b1;
      i_in_data = k;
      step();
      chk($sformatf("t2_data%0d", k), o_out_data, k);
      chk($sformatf("t2_count%0d", k), {30'd0, o_count}, 32'd1);
      chk($sformatf("t2_ready%0d", k), {31'd0, o_in_ready}, 32'd1);
    end
    i_in_valid = 1'b0;
    step();
    chk("t2_empty", {31'd0, o_out_valid}, 32'd0);

    // 3. stall fills the skid slot
    i_out_ready = 1'b0;
    i_in_valid = 1'b1;
    i_in_data = 32'hA;
    step();
    i_in_data = 32'hB;
    step();
    i_in_valid = 1'b0;
    i_in_data = 32'hFFFF_FFFF;
    chk("t3_count", {30'd0, o_count}, 32'd2);
    chk("t3_ready", {31'd0, o_in_ready}, 32'd0);
    chk("t3_data", o_out_data, 32'hA);
    step();
    chk("t3_hold_data", o_out_data, 32'hA);
    chk("t3_hold_count", {30'd0, o_count}, 32'd2);
    i_out_ready = 1'b1;
    step();
    chk("t3_pop_a", o_out_data, 32'hB);
    chk("t3_pop_a_cnt", {30'd0, o_count}, 32'd1);
    step();
    chk("t3_empty", {31'd0, o_out_valid}, 32'd0);

    // 4. FULL, out_ready pulsed once with 0xC waiting
    i_out_ready = 1'b0;
    i_in_valid = 1'b1;
    i_in_data = 32'hA;
    step();
    i_in_data = 32'hB;
    step();
    i_in_data = 32'hC;
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
    chk("t4_count", {30'd0, o_count}, 32'd1);
    chk("t4_ready", {31'd0, o_in_ready}, 32'd1);
    chk("t4_data", o_out_data, 32'hB);
    step();
    i_in_valid = 1'b0;
    chk("t4_acc_count", {30'd0, o_count}, 32'd2);
    chk("t4_acc_data", o_out_data, 32'hB);
    i_out_ready = 1'b1;
    step();
    chk("t4_out_c", o_out_data, 32'hC);
    step();
    chk("t4_empty", {31'd0, o_out_valid}, 32'd0);

    // 5. flush while FULL with a word offered
    i_out_ready = 1'b0;
    i_in_valid = 1'b1;
    i_in_data = 32'h11;
    step();
    i_in_data = 32'h12;
    step();
    chk("t5_full", {30'd0, o_count}, 32'd2);
    i_flush = 1'b1;
    i_in_data = 32'hE;
    step();
    i_flush = 1'b0;
    i_in_valid = 1'b0;
    chk("t5_count", {30'd0, o_count}, 32'd0);
    chk("t5_valid", {31'd0, o_out_valid}, 32'd0);
    chk("t5_ready", {31'd0, o_in_ready}, 32'd1);
    i_out_ready = 1'b1;
    step();
    chk("t5_no_e", {31'd0, o_out_valid}, 32'd0);
    // stage still works after flush
    i_in_valid = 1'b1;
    i_in_data = 32'h55;
    step();
    i_in_valid = 1'b0;
    chk("t5_after", o_out_data, 32'h55);

    // 6. asynchronous reset mid-stream while FULL
    i_out_ready = 1'b0;
    i_in_valid = 1'b1;
    i_in_data = 32'h21;
    step();
    i_in_data = 32'h22;
    step();
    chk("t6_full", {30'd0, o_count}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", {31'd0, o_out_valid}, 32'd0);
    chk("t6_count", {30'd0, o_count}, 32'd0);
    chk("t6_ready", {31'd0, o_in_ready}, 32'd1);
    i_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("t6_post", {31'd0, o_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
